// File: rtl/tpi_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : tpi_scan_ctrl_if
// Purpose  : TPI register-bus and change-event stream bundle for tpi_scan_ctrl
// Revision : 1.0  initial release
// ============================================================================
interface tpi_scan_ctrl_if;
    logic       tpi_cs;
    logic       tpi_write;
    logic [2:0] tpi_rs;
    logic [7:0] tpi_wdata;
    logic [7:0] tpi_rdata;
    logic       evt_valid;
    logic       evt_ready;
    logic [2:0] evt_row;
    logic [7:0] evt_data;

    modport master (
        output tpi_cs, tpi_write, tpi_rs, tpi_wdata,
        input  tpi_rdata,
        output evt_valid, evt_row, evt_data,
        input  evt_ready
    );

    modport slave (
        input  tpi_cs, tpi_write, tpi_rs, tpi_wdata,
        output tpi_rdata,
        input  evt_valid, evt_row, evt_data,
        output evt_ready
    );
endinterface
`default_nettype wire

// File: rtl/tpi_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tpi_scan_ctrl
// Purpose  : Keyboard-matrix scanner mastering a 6523-style TPI; reports
//            per-row column changes on a valid/ready event stream.
//            Optional TPI_SCAN_DEBOUNCE_EN: change must persist two frames.
// Revision : 1.0  initial release
// ============================================================================
module tpi_scan_ctrl #(
    parameter int ROWS     = 8,
    parameter int SETTLE   = 4,
    parameter int SCAN_GAP = 1000
) (
    input  wire             clock,
    input  wire             reset,
    input  wire             enable,
    output logic            frame_done,
    tpi_scan_ctrl_if.master bus
);
    localparam int GW = $clog2(SCAN_GAP + 1);
    localparam int SW = $clog2(SETTLE + 1);

    typedef enum logic [3:0] {
        S_INIT_A = 4'd0, S_INIT_B = 4'd1, S_PARK   = 4'd2, S_IDLE = 4'd3,
        S_DRIVE  = 4'd4, S_SETTLE = 4'd5, S_SAMPLE = 4'd6, S_CMP  = 4'd7,
        S_EMIT   = 4'd8, S_NEXT   = 4'd9
    } state_t;

    state_t        r_state, w_state;
    logic [2:0]    r_row, w_row;
    logic [GW-1:0] r_gap, w_gap;
    logic [SW-1:0] r_set, w_set;
    logic          r_cs, w_cs;
    logic          r_wr, w_wr;
    logic [2:0]    r_rs, w_rs;
    logic [7:0]    r_wd, w_wd;
    logic          r_ev, w_ev;
    logic [2:0]    r_er, w_er;
    logic [7:0]    r_ed, w_ed;
    logic          r_fd, w_fd;
    logic          w_snap_we;
    logic          w_diff;
    logic [7:0]    r_snap [ROWS];
`ifdef TPI_SCAN_DEBOUNCE_EN
    logic [7:0]    r_cand [ROWS];
    logic [ROWS-1:0] r_cval;
    logic          w_cand_ld;
    logic          w_cval_clr;
`endif

    assign w_diff = (bus.tpi_rdata != r_snap[r_row]);

    // Bus fields are computed a state ahead so every strobe is a clean register output.
    always_comb begin
        w_state   = r_state;
        w_row     = r_row;
        w_gap     = r_gap;
        w_set     = r_set;
        w_cs      = 1'b0;
        w_wr      = r_wr;
        w_rs      = r_rs;
        w_wd      = r_wd;
        w_ev      = r_ev;
        w_er      = r_er;
        w_ed      = r_ed;
        w_fd      = 1'b0;
        w_snap_we = 1'b0;
`ifdef TPI_SCAN_DEBOUNCE_EN
        w_cand_ld  = 1'b0;
        w_cval_clr = 1'b0;
`endif
        case (r_state)
            S_INIT_A: begin
                w_cs = 1'b1; w_wr = 1'b1; w_rs = 3'd3; w_wd = 8'hFF;
                w_state = S_INIT_B;
            end
            S_INIT_B: begin
                w_cs = 1'b1; w_wr = 1'b1; w_rs = 3'd4; w_wd = 8'h00;
                w_state = S_PARK;
            end
            S_PARK: begin
                w_cs = 1'b1; w_wr = 1'b1; w_rs = 3'd0; w_wd = 8'hFF;
                w_gap = '0;
                w_state = S_IDLE;
            end
            S_IDLE: begin
                if (!enable) begin
                    w_gap = '0;
                end else if (r_gap == GW'(SCAN_GAP - 1)) begin
                    w_gap   = '0;
                    w_row   = 3'd0;
                    w_state = S_DRIVE;
                end else begin
                    w_gap = r_gap + 1'b1;
                end
            end
            S_DRIVE: begin
                w_cs = 1'b1; w_wr = 1'b1; w_rs = 3'd0; w_wd = ~(8'd1 << r_row);
                w_set = '0;
                w_state = S_SETTLE;
            end
            S_SETTLE: begin
                if (r_set == SW'(SETTLE - 1)) w_state = S_SAMPLE;
                else                          w_set   = r_set + 1'b1;
            end
            S_SAMPLE: begin
                w_cs = 1'b1; w_wr = 1'b0; w_rs = 3'd1;
                w_state = S_CMP;
            end
            S_CMP: begin
                // tpi_rdata is valid here: the read strobe is on the bus this cycle.
                w_state = S_NEXT;
`ifdef TPI_SCAN_DEBOUNCE_EN
                if (!w_diff) begin
                    w_cval_clr = 1'b1;
                end else if (r_cval[r_row] && (r_cand[r_row] == bus.tpi_rdata)) begin
                    w_ev = 1'b1; w_er = r_row; w_ed = bus.tpi_rdata;
                    w_state = S_EMIT;
                end else begin
                    w_cand_ld = 1'b1;
                end
`else
                if (w_diff) begin
                    w_ev = 1'b1; w_er = r_row; w_ed = bus.tpi_rdata;
                    w_state = S_EMIT;
                end
`endif
            end
            S_EMIT: begin
                if (r_ev && bus.evt_ready) begin
                    w_ev      = 1'b0;
                    w_snap_we = 1'b1;
                    w_state   = S_NEXT;
                end
            end
            S_NEXT: begin
                if (r_row == 3'(ROWS - 1)) begin
                    w_fd    = 1'b1;
                    w_state = S_PARK;
                end else begin
                    w_row   = r_row + 3'd1;
                    w_state = S_DRIVE;
                end
            end
            default: w_state = S_INIT_A;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_INIT_A;
            r_row   <= 3'd0;
            r_gap   <= '0;
            r_set   <= '0;
            r_cs    <= 1'b0;
            r_wr    <= 1'b0;
            r_rs    <= 3'd0;
            r_wd    <= 8'h00;
            r_ev    <= 1'b0;
            r_er    <= 3'd0;
            r_ed    <= 8'h00;
            r_fd    <= 1'b0;
            for (int i = 0; i < ROWS; i++) r_snap[i] <= 8'hFF;
`ifdef TPI_SCAN_DEBOUNCE_EN
            for (int i = 0; i < ROWS; i++) r_cand[i] <= 8'hFF;
            r_cval <= '0;
`endif
        end else begin
            r_state <= w_state;
            r_row   <= w_row;
            r_gap   <= w_gap;
            r_set   <= w_set;
            r_cs    <= w_cs;
            r_wr    <= w_wr;
            r_rs    <= w_rs;
            r_wd    <= w_wd;
            r_ev    <= w_ev;
            r_er    <= w_er;
            r_ed    <= w_ed;
            r_fd    <= w_fd;
            if (w_snap_we) r_snap[r_row] <= r_ed;
`ifdef TPI_SCAN_DEBOUNCE_EN
            if (w_cand_ld) begin
                r_cand[r_row] <= bus.tpi_rdata;
                r_cval[r_row] <= 1'b1;
            end
            if (w_cval_clr) r_cval[r_row] <= 1'b0;
`endif
        end
    end

    assign bus.tpi_cs    = r_cs;
    assign bus.tpi_write = r_wr;
    assign bus.tpi_rs    = r_rs;
    assign bus.tpi_wdata = r_wd;
    assign bus.evt_valid = r_ev;
    assign bus.evt_row   = r_er;
    assign bus.evt_data  = r_ed;
    assign frame_done    = r_fd;

endmodule
`default_nettype wire

// File: tb/tb_tpi_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_tpi_scan_ctrl
// Purpose  : Self-checking bench for tpi_scan_ctrl with a key-matrix TPI model
//            and a frame-level event reference (honours TPI_SCAN_DEBOUNCE_EN).
// Revision : 1.0  initial release
// ============================================================================
module tb_tpi_scan_ctrl;
    localparam int ROWS   = 8;
    localparam int SETTLE = 4;
    localparam int GAP    = 40;

    typedef struct packed { logic [2:0] row; logic [7:0] data; } ev_t;
    typedef struct {
        string      name;
        int         cyc;
        logic       cs;
        logic       wr;
        logic [2:0] rs;
        logic [7:0] wd;
    } vec_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic enable = 1'b1;
    logic ready = 1'b0;
    logic hold_ready = 1'b0;
    logic frame_done;
    logic [7:0] rd_col, rd_val;

    tpi_scan_ctrl_if bus();
    assign bus.evt_ready = ready;
    assign bus.tpi_rdata = rd_val;

    tpi_scan_ctrl #(.ROWS(ROWS), .SETTLE(SETTLE), .SCAN_GAP(GAP)) dut (
        .clock(clock), .reset(reset), .enable(enable),
        .frame_done(frame_done), .bus(bus)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int mcyc = 0;
    int frames = 0;
    int strobes = 0;
    int drv_row = 0;
    int last_drv = -1000;
    int row_evts [ROWS];
    logic [7:0] row_last [ROWS];
    logic [7:0] porta = 8'hFF;
    logic [7:0] keys [ROWS];
    logic [7:0] next_keys [ROWS];
    logic [7:0] m_snap [ROWS];
    logic [7:0] m_cand [ROWS];
    logic       m_cval [ROWS];
    ev_t        got [$];
    logic [11:0] prev_bus = '0;
    logic        prev_valid = 1'b0, prev_acc = 1'b0, prev_fd = 1'b0;
    logic [10:0] prev_evt = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, mcyc);
        end
    endtask

    // Matrix model: each row line pulled low on port A selects that row's keys.
    always_comb begin
        rd_col = 8'hFF;
        for (int r = 0; r < ROWS; r++)
            if (!porta[r]) rd_col = rd_col & keys[r];
        rd_val = (bus.tpi_cs && !bus.tpi_write && bus.tpi_rs == 3'd1) ? rd_col
                                                                      : (8'hA5 ^ mcyc[7:0]);
    end

    // Frame-level reference: what one full pass over the matrix must report.
    task automatic model_frame();
        ev_t exp [$];
        logic [7:0] s;
        for (int r = 0; r < ROWS; r++) begin
            s = keys[r];
            if (s != m_snap[r]) begin
`ifdef TPI_SCAN_DEBOUNCE_EN
                if (m_cval[r] && m_cand[r] == s) begin
                    exp.push_back({3'(r), s});
                    m_snap[r] = s;
                end else begin
                    m_cand[r] = s;
                    m_cval[r] = 1'b1;
                end
`else
                exp.push_back({3'(r), s});
                m_snap[r] = s;
`endif
            end else begin
                m_cval[r] = 1'b0;
            end
        end
        chk("frame_event_count", 64'(got.size()), 64'(exp.size()));
        for (int i = 0; i < exp.size() && i < got.size(); i++)
            chk("frame_event", 64'(got[i]), 64'(exp[i]));
        got.delete();
    endtask

    always @(negedge clock) begin
        mcyc++;
        if (reset) begin
            drv_row = 0;
            got.delete();
            for (int r = 0; r < ROWS; r++) begin
                m_snap[r] = 8'hFF; m_cand[r] = 8'hFF; m_cval[r] = 1'b0;
                keys[r] = next_keys[r];
            end
            prev_bus = '0; prev_valid = 1'b0; prev_acc = 1'b0; prev_fd = 1'b0;
        end else begin
            if (!bus.tpi_cs)
                chk("bus_fields_held", 64'({bus.tpi_write, bus.tpi_rs, bus.tpi_wdata}), 64'(prev_bus));
            prev_bus = {bus.tpi_write, bus.tpi_rs, bus.tpi_wdata};
            if (bus.tpi_cs) strobes++;
            if (bus.tpi_cs && bus.tpi_write && bus.tpi_rs == 3'd0) begin
                porta = bus.tpi_wdata;
                if (bus.tpi_wdata != 8'hFF) begin
                    chk("drive_row_pattern", 64'(bus.tpi_wdata), 64'(8'(~(8'd1 << drv_row))));
                    drv_row++;
                    last_drv = mcyc;
                end
            end
            if (bus.tpi_cs && !bus.tpi_write) begin
                chk("read_rs", 64'(bus.tpi_rs), 64'd1);
                chk("read_after_drive", 64'(mcyc - last_drv), 64'(SETTLE + 1));
            end
            if (bus.evt_valid) chk("no_strobe_in_emit", 64'(bus.tpi_cs), 64'd0);
            if (prev_valid && !prev_acc)
                chk("evt_held", 64'({bus.evt_valid, bus.evt_row, bus.evt_data}), 64'({1'b1, prev_evt}));
            prev_valid = bus.evt_valid;
            prev_acc   = bus.evt_valid && ready;
            prev_evt   = {bus.evt_row, bus.evt_data};
            if (bus.evt_valid && ready) begin
                got.push_back({bus.evt_row, bus.evt_data});
                row_evts[bus.evt_row]++;
                row_last[bus.evt_row] = bus.evt_data;
            end
            if (frame_done) begin
                chk("frame_done_single", 64'(prev_fd), 64'd0);
                chk("rows_per_frame", 64'(drv_row), 64'(ROWS));
                drv_row = 0;
                model_frame();
                frames++;
                for (int r = 0; r < ROWS; r++) keys[r] = next_keys[r];
            end
            prev_fd = frame_done;
        end
    end

    initial begin
        forever begin
            @(posedge clock);
            #1;
            ready = hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk_all_zero(input string name);
        chk(name, 64'({bus.tpi_cs, bus.tpi_write, bus.tpi_rs, bus.tpi_wdata, bus.evt_valid,
                       bus.evt_row, bus.evt_data, frame_done}), 64'd0);
    endtask

    task automatic run_init_table();
        vec_t tbl [7];
        int nstrobe = 0;
        tbl[0] = '{"init_c0_idle",   0,       1'b0, 1'b0, 3'd0, 8'h00};
        tbl[1] = '{"init_ddra",      1,       1'b1, 1'b1, 3'd3, 8'hFF};
        tbl[2] = '{"init_ddrb",      2,       1'b1, 1'b1, 3'd4, 8'h00};
        tbl[3] = '{"init_park",      3,       1'b1, 1'b1, 3'd0, 8'hFF};
        tbl[4] = '{"gap_first",      4,       1'b0, 1'b1, 3'd0, 8'hFF};
        tbl[5] = '{"gap_last",       3 + GAP, 1'b0, 1'b1, 3'd0, 8'hFF};
        tbl[6] = '{"first_drive",    4 + GAP, 1'b1, 1'b1, 3'd0, 8'hFE};
        reset = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk_all_zero("reset_state");
        @(posedge clock);
        #1 reset = 1'b0;
        for (int c = 0; c <= 4 + GAP; c++) begin
            @(negedge clock);
            if (c >= 4 && c <= 3 + GAP && bus.tpi_cs) nstrobe++;
            for (int i = 0; i < 7; i++)
                if (tbl[i].cyc == c)
                    chk(tbl[i].name, 64'({bus.tpi_cs, bus.tpi_write, bus.tpi_rs, bus.tpi_wdata}),
                        64'({tbl[i].cs, tbl[i].wr, tbl[i].rs, tbl[i].wd}));
        end
        chk("gap_no_strobe", 64'(nstrobe), 64'd0);
    endtask

    task automatic wait_frames(input int n);
        int target = frames + n;
        int budget = n * 1500;
        while (frames < target && budget > 0) begin
            @(negedge clock);
            budget--;
        end
        if (frames < target) chk("frame_timeout", 64'(frames), 64'(target));
    endtask

    initial begin
        int b1, b5, s0, n;
        for (int r = 0; r < ROWS; r++) begin
            next_keys[r] = 8'hFF; keys[r] = 8'hFF; row_evts[r] = 0; row_last[r] = 8'hFF;
        end

        run_init_table();
        wait_frames(2);

        // Single key on row 2: pressed, held, released.
        b1 = row_evts[2];
        next_keys[2] = 8'hFB;
        wait_frames(3);
        chk("row2_press_events", 64'(row_evts[2] - b1), 64'd1);
        chk("row2_press_data", 64'(row_last[2]), 64'hFB);
        next_keys[2] = 8'hFF;
        wait_frames(3);
        chk("row2_release_events", 64'(row_evts[2] - b1), 64'd2);
        chk("row2_release_data", 64'(row_last[2]), 64'hFF);

        // Two rows change while the consumer stalls.
        b1 = row_evts[1]; b5 = row_evts[5];
        hold_ready = 1'b1;
        next_keys[1] = 8'hEF; next_keys[5] = 8'h7F;
        n = 0;
        while (!bus.evt_valid && n < 2000) begin @(negedge clock); n++; end
        chk("stall_evt_seen", 64'(bus.evt_valid), 64'd1);
        chk("stall_evt_row", 64'(bus.evt_row), 64'd1);
        chk("stall_evt_data", 64'(bus.evt_data), 64'hEF);
        s0 = strobes;
        repeat (50) @(negedge clock);
        chk("stall_no_strobes", 64'(strobes - s0), 64'd0);
        chk("stall_still_row1", 64'({bus.evt_valid, bus.evt_row}), 64'({1'b1, 3'd1}));
        hold_ready = 1'b0;
        wait_frames(2);
        chk("row1_events", 64'(row_evts[1] - b1), 64'd1);
        chk("row5_events", 64'(row_evts[5] - b5), 64'd1);

        // Enable low while idle, then measure restart latency.
        n = 0;
        while (!frame_done && n < 2000) begin @(negedge clock); n++; end
        enable = 1'b0;
        repeat (2) @(negedge clock);
        s0 = strobes;
        repeat (2000) @(negedge clock);
        chk("disabled_no_strobes", 64'(strobes - s0), 64'd0);
        @(posedge clock);
        #1 enable = 1'b1;
        n = 0;
        forever begin
            @(negedge clock);
            if (bus.tpi_cs || n > 4 * GAP) break;
            n++;
        end
        // DRIVE is entered SCAN_GAP cycles after enable; its registered strobe follows one cycle later.
        chk("enable_to_drive", 64'(n), 64'(GAP + 1));
        chk("enable_drive_row0", 64'({bus.tpi_cs, bus.tpi_write, bus.tpi_rs, bus.tpi_wdata}),
            64'({1'b1, 1'b1, 3'd0, 8'hFE}));

        // Reset during SETTLE of row 4 with a key held on row 2.
        next_keys[2] = 8'hFB;
        wait_frames(3);
        n = 0;
        while (!(bus.tpi_cs && bus.tpi_write && bus.tpi_rs == 3'd0 && bus.tpi_wdata == 8'hEF)
               && n < 2000) begin
            @(negedge clock); n++;
        end
        chk("row4_drive_seen", 64'(bus.tpi_wdata), 64'hEF);
        reset = 1'b1;
        @(negedge clock);
        chk_all_zero("reset_mid_settle");
        b1 = row_evts[2];
        run_init_table();
        wait_frames(3);
        chk("rereport_after_reset", 64'(row_evts[2] - b1), 64'd1);
        chk("rereport_data", 64'(row_last[2]), 64'hFB);

        // Randomized key activity checked frame by frame by the reference.
        for (int f = 0; f < 10; f++) begin
            for (int r = 0; r < ROWS; r++)
                if ($urandom_range(0, 3) == 0) next_keys[r] = 8'($urandom);
            wait_frames(1);
        end
        wait_frames(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
